// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch_unit (master) and imem (slave).
interface fetch_unit_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns fetch PC, one outstanding imem request, one-entry output buffer to IF/ID.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hE000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_if,
  input  logic          redirect_valid,
  input  logic [15:0]   redirect_pc,
  fetch_unit_if.master  imem,
  output logic [15:0]   if_pc,
  output logic [15:0]   if_instr,
  output logic          if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]   perf_fetched,
  output logic [15:0]   perf_bubbles
`endif
);

  localparam int unsigned PW = 16;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e        state_q;
  logic [PW-1:0] fetch_pc_q;
  logic [PW-1:0] req_pc_q;
  logic          ob_valid_q;
  logic [PW-1:0] ob_pc_q;
  logic [15:0]   ob_instr_q;

  logic req_c;
  logic grant_c;
  logic load_c;

  // Only request when the buffer will be free by the time the response lands.
  always_comb begin
    req_c   = 1'b0;
    grant_c = 1'b0;
    load_c  = 1'b0;
    if (!rst && (state_q == ST_REQ) && !redirect_valid) begin
      req_c = !ob_valid_q || !stall_if;
    end
    grant_c = req_c && imem.imem_gnt;
    load_c  = (state_q == ST_WAIT) && imem.imem_rvalid && !redirect_valid;
  end

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = fetch_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      ob_valid_q <= 1'b0;
      ob_pc_q    <= '0;
      ob_instr_q <= NOP_INSTR;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (grant_c) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + PW'(1);
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.imem_rvalid) begin
            state_q <= ST_REQ;
          end else if (redirect_valid) begin
            state_q <= ST_DROP;
          end
        end
        // A response consumed here leaves nothing outstanding, even under redirect.
        ST_DROP: begin
          if (imem.imem_rvalid) begin
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_REQ;
      endcase

      if (load_c) begin
        ob_valid_q <= 1'b1;
        ob_pc_q    <= req_pc_q;
        ob_instr_q <= imem.imem_rdata;
      end else if (!stall_if) begin
        ob_valid_q <= 1'b0;
      end

      // Redirect overrides any PC advance and flushes the buffer.
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        ob_valid_q <= 1'b0;
      end
    end
  end

  assign if_valid = ob_valid_q;
  assign if_pc    = ob_pc_q;
  assign if_instr = ob_valid_q ? ob_instr_q : NOP_INSTR;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched_q;
  logic [15:0] perf_bubbles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (load_c) begin
        perf_fetched_q <= perf_fetched_q + 16'(1);
      end
      if (!stall_if && !ob_valid_q) begin
        perf_bubbles_q <= perf_bubbles_q + 16'(1);
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
